// File: rtl/alu_mul_sequencer.sv
// Shift-and-add multiplier that borrows a shared external ALU for its adds and shifts.
// Produces the low 32 bits of op_a * op_b; one ADD cycle per set multiplier bit.
module alu_mul_sequencer (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic [31:0] op_a_i,
  input  logic [31:0] op_b_i,
  input  logic [31:0] alu_result_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [31:0] product_o,
  output logic [3:0]  alu_control_o,
  output logic [31:0] src_a_o,
  output logic [31:0] src_b_o
);

  localparam logic [3:0] OpAdd  = 4'b0000;
  localparam logic [3:0] OpShl  = 4'b1010;
  localparam logic [3:0] OpPass = 4'b0111;

  typedef enum logic [1:0] {StIdle, StAdd, StShift, StDone} state_e;

  state_e      state_q, state_d;
  logic [31:0] acc_q, acc_d;
  logic [31:0] mcand_q, mcand_d;
  logic [31:0] mplier_q, mplier_d;
  logic [31:0] product_q, product_d;
  logic [31:0] mplier_shr;

  assign mplier_shr = mplier_q >> 1;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= StIdle;
      acc_q     <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      product_q <= product_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    acc_d         = acc_q;
    mcand_d       = mcand_q;
    mplier_d      = mplier_q;
    product_d     = product_q;
    busy_o        = 1'b0;
    done_o        = 1'b0;
    alu_control_o = OpPass;
    src_a_o       = '0;
    src_b_o       = '0;
    product_o     = product_q;

    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          acc_d    = '0;
          mcand_d  = op_a_i;
          mplier_d = op_b_i;
          if (op_b_i == '0) begin
            state_d = StDone;
          end else if (op_b_i[0]) begin
            state_d = StAdd;
          end else begin
            state_d = StShift;
          end
        end
      end
      StAdd: begin
        busy_o        = 1'b1;
        alu_control_o = OpAdd;
        src_a_o       = acc_q;
        src_b_o       = mcand_q;
        acc_d         = alu_result_i;
        state_d       = StShift;
      end
      StShift: begin
        busy_o        = 1'b1;
        alu_control_o = OpShl;
        src_a_o       = mcand_q;
        src_b_o       = 32'd1;
        mcand_d       = alu_result_i;
        mplier_d      = mplier_shr;
        // Look one bit ahead: mplier[1] is the next bit once this shift lands.
        if (mplier_shr == '0) begin
          state_d = StDone;
        end else if (mplier_q[1]) begin
          state_d = StAdd;
        end else begin
          state_d = StShift;
        end
      end
      StDone: begin
        done_o    = 1'b1;
        product_o = acc_q;
        product_d = acc_q;
        state_d   = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

endmodule

// File: tb/tb_alu_mul_sequencer.sv
// Directed bench for alu_mul_sequencer with a behavioural model of the shared ALU.
module tb_alu_mul_sequencer;

  logic        clk;
  logic        rst;
  logic        start;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic [31:0] alu_result;
  logic        busy;
  logic        done;
  logic [31:0] product;
  logic [3:0]  alu_control;
  logic [31:0] src_a;
  logic [31:0] src_b;

  int n_cmp  = 0;
  int n_fail = 0;

  localparam logic [3:0] OpAdd  = 4'b0000;
  localparam logic [3:0] OpShl  = 4'b1010;
  localparam logic [3:0] OpPass = 4'b0111;

  alu_mul_sequencer dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .start_i      (start),
    .op_a_i       (op_a),
    .op_b_i       (op_b),
    .alu_result_i (alu_result),
    .busy_o       (busy),
    .done_o       (done),
    .product_o    (product),
    .alu_control_o(alu_control),
    .src_a_o      (src_a),
    .src_b_o      (src_b)
  );

  // Shared ALU model: ADD, shift-left, pass-through of A.
  always_comb begin
    alu_result = src_a;
    if (alu_control == OpAdd) alu_result = src_a + src_b;
    else if (alu_control == OpShl) alu_result = src_a << src_b[4:0];
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Start a multiply, scramble the operand inputs afterwards, and check latency/result.
  task automatic run_mul(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp_prod, input int exp_lat);
    int n;
    int busy_bad;
    logic [31:0] prev_prod;
    prev_prod = product;
    start = 1'b1;
    op_a  = a;
    op_b  = b;
    chk({tag, "_prod_hold_idle"}, product, prev_prod);
    tick();
    start = 1'b0;
    n = 1;
    busy_bad = 0;
    while (!done && n < exp_lat + 8) begin
      if (!busy) busy_bad++;
      if (product !== prev_prod) busy_bad++;
      op_a = $urandom;
      op_b = $urandom;
      tick();
      n++;
    end
    chk({tag, "_latency"}, n, exp_lat);
    chk({tag, "_busy_hold_errs"}, busy_bad, 0);
    chk({tag, "_product"}, product, exp_prod);
    chk({tag, "_busy_in_done"}, {31'd0, busy}, 0);
    tick();
    chk({tag, "_done_pulse"}, {31'd0, done}, 0);
    chk({tag, "_product_held"}, product, exp_prod);
  endtask

  initial begin
    logic [3:0] exp_ops [5];
    int add_seen;
    exp_ops[0] = OpAdd;
    exp_ops[1] = OpShl;
    exp_ops[2] = OpShl;
    exp_ops[3] = OpAdd;
    exp_ops[4] = OpShl;

    rst = 1'b1; start = 1'b0; op_a = '0; op_b = '0;
    tick();
    tick();
    rst = 1'b0;
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_done", {31'd0, done}, 0);
    chk("rst_product", product, 0);
    chk("idle_ctrl", {28'd0, alu_control}, {28'd0, OpPass});
    chk("idle_src_a", src_a, 0);
    chk("idle_src_b", src_b, 0);

    // 3x5: opcode sequence per cycle.
    start = 1'b1; op_a = 32'd3; op_b = 32'd5;
    tick();
    start = 1'b0;
    chk("3x5_t1_src_a", src_a, 0);
    chk("3x5_t1_src_b", src_b, 3);
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("3x5_op_t%0d", i + 1), {28'd0, alu_control}, {28'd0, exp_ops[i]});
      chk($sformatf("3x5_busy_t%0d", i + 1), {31'd0, busy}, 1);
      if (i == 1) begin
        chk("3x5_t2_src_a", src_a, 3);
        chk("3x5_t2_src_b", src_b, 1);
      end
      tick();
    end
    chk("3x5_done_t6", {31'd0, done}, 1);
    chk("3x5_product", product, 15);
    tick();
    chk("3x5_t7_done", {31'd0, done}, 0);
    chk("3x5_t7_product", product, 15);

    // op_b == 0: straight to DONE, never an ADD.
    start = 1'b1; op_a = 32'h1234; op_b = 32'd0;
    chk("zero_prod_hold", product, 15);
    tick();
    start = 1'b0;
    add_seen = (alu_control == OpAdd) ? 1 : 0;
    chk("zero_done_t1", {31'd0, done}, 1);
    chk("zero_product", product, 0);
    tick();
    add_seen += (alu_control == OpAdd) ? 1 : 0;
    chk("zero_no_add", add_seen, 0);
    chk("zero_idle_done", {31'd0, done}, 0);

    run_mul("ffxff", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 65);
    run_mul("fexthree", 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFA, 5);
    run_mul("bit16sq", 32'h0001_0000, 32'h0001_0000, 32'h0, 19);
    run_mul("neg3x5", 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFF1, 6);

    // Start during the operation is ignored.
    start = 1'b1; op_a = 32'd3; op_b = 32'd5;
    tick();
    start = 1'b0;
    tick();
    tick();
    start = 1'b1; op_a = 32'd7; op_b = 32'd7;
    tick();
    start = 1'b0;
    tick();
    tick();
    chk("ign_done_t6", {31'd0, done}, 1);
    chk("ign_product", product, 15);
    tick();
    chk("ign_t7_busy", {31'd0, busy}, 0);
    chk("ign_t7_ctrl", {28'd0, alu_control}, {28'd0, OpPass});
    // Start in the very first IDLE cycle after DONE is accepted.
    run_mul("b2b_2x3", 32'd2, 32'd3, 32'd6, 5);

    // Reset mid-operation aborts.
    start = 1'b1; op_a = 32'd3; op_b = 32'd5;
    tick();
    start = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_busy", {31'd0, busy}, 0);
    chk("abort_done", {31'd0, done}, 0);
    chk("abort_product", product, 0);
    add_seen = 0;
    for (int i = 0; i < 6; i++) begin
      add_seen += done ? 1 : 0;
      tick();
    end
    chk("abort_no_done", add_seen, 0);

    // Reset wins over a simultaneous start.
    rst = 1'b1; start = 1'b1; op_a = 32'd9; op_b = 32'd9;
    tick();
    rst = 1'b0; start = 1'b0;
    chk("rst_prio_busy", {31'd0, busy}, 0);
    tick();
    chk("rst_prio_still_idle", {31'd0, busy | done}, 0);

    run_mul("post_rst_2x2", 32'd2, 32'd2, 32'd4, 4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
